// File: rtl/icache.sv
// Direct-mapped read-only instruction cache. Hits answer in one cycle; misses
// fill a whole line from the memory controller one word at a time.
module icache #(
  parameter int INDEX_BITS  = 6,
  parameter int OFFSET_BITS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        if_req_valid,
  input  logic [31:0] if_pc,
  input  logic        flush,
  output logic        ic_hit,
  output logic [31:0] ic_instr,
  output logic        mc_req,
  output logic [31:0] mc_addr,
  input  logic        mc_data_valid,
  input  logic [31:0] mc_data
);
  localparam int TAG_BITS = 32 - INDEX_BITS - OFFSET_BITS - 2;
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int WORDS    = 1 << OFFSET_BITS;
  localparam int TAG_LSB  = INDEX_BITS + OFFSET_BITS + 2;

  typedef enum logic [1:0] {IDLE, FILL, RESP} state_t;

  state_t                  state_q;
  logic [OFFSET_BITS-1:0]  cnt_q;
  logic                    killed_q;
  logic                    ic_hit_q;
  logic [31:0]             ic_instr_q;
  logic                    mc_req_q;
  logic [31:0]             mc_addr_q;
  logic [TAG_BITS-1:0]     req_tag_q;
  logic [INDEX_BITS-1:0]   req_idx_q;
  logic [OFFSET_BITS-1:0]  req_word_q;

  logic [LINES-1:0]        valid_q;
  logic [TAG_BITS-1:0]     tag_q  [LINES];
  logic [31:0]             data_q [LINES][WORDS];
  logic [31:0]             line_q [WORDS];

  logic [TAG_BITS-1:0]     pc_tag;
  logic [INDEX_BITS-1:0]   pc_idx;
  logic [OFFSET_BITS-1:0]  pc_word;
  logic                    lookup_hit;
  logic                    unused_pc_bits;

  assign pc_tag         = if_pc[31:TAG_LSB];
  assign pc_idx         = if_pc[TAG_LSB-1:OFFSET_BITS+2];
  assign pc_word        = if_pc[OFFSET_BITS+1:2];
  assign unused_pc_bits = ^if_pc[1:0];
  assign lookup_hit     = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      killed_q   <= 1'b0;
      ic_hit_q   <= 1'b0;
      ic_instr_q <= '0;
      mc_req_q   <= 1'b0;
      mc_addr_q  <= '0;
      valid_q    <= '0;
    end else if (rdy) begin
      ic_hit_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (if_req_valid && !flush) begin
            if (lookup_hit) begin
              ic_hit_q   <= 1'b1;
              ic_instr_q <= data_q[pc_idx][pc_word];
            end else begin
              req_tag_q  <= pc_tag;
              req_idx_q  <= pc_idx;
              req_word_q <= pc_word;
              mc_addr_q  <= {if_pc[31:OFFSET_BITS+2], {(OFFSET_BITS+2){1'b0}}};
              mc_req_q   <= 1'b1;
              cnt_q      <= '0;
              state_q    <= FILL;
            end
          end
        end
        FILL: begin
          // The memory transaction cannot be aborted, so a flush only marks the response dead.
          if (flush) killed_q <= 1'b1;
          if (mc_data_valid) begin
            line_q[cnt_q] <= mc_data;
            cnt_q         <= cnt_q + 1'b1;
            if (cnt_q == {OFFSET_BITS{1'b1}}) begin
              mc_req_q           <= 1'b0;
              valid_q[req_idx_q] <= 1'b1;
              tag_q[req_idx_q]   <= req_tag_q;
              for (int w = 0; w < WORDS - 1; w++) data_q[req_idx_q][w] <= line_q[w];
              data_q[req_idx_q][WORDS-1] <= mc_data;
              state_q            <= RESP;
            end
          end
        end
        RESP: begin
          ic_hit_q   <= !killed_q && !flush;
          ic_instr_q <= line_q[req_word_q];
          killed_q   <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ic_hit   = ic_hit_q;
  assign ic_instr = ic_instr_q;
  assign mc_req   = mc_req_q;
  assign mc_addr  = mc_addr_q;
endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: expected instructions are queued when a fetch is
// driven and popped whenever the cache pulses ic_hit.
module tb_icache;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        if_req_valid = 1'b0;
  logic [31:0] if_pc = '0;
  logic        flush = 1'b0;
  logic        ic_hit;
  logic [31:0] ic_instr;
  logic        mc_req;
  logic [31:0] mc_addr;
  logic        mc_data_valid = 1'b0;
  logic [31:0] mc_data = '0;

  int          n_total = 0;
  int          n_bad = 0;
  logic [31:0] exp_q [$];

  icache dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_req_valid(if_req_valid), .if_pc(if_pc), .flush(flush),
    .ic_hit(ic_hit), .ic_instr(ic_instr),
    .mc_req(mc_req), .mc_addr(mc_addr),
    .mc_data_valid(mc_data_valid), .mc_data(mc_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (ic_hit === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_hit", {31'b0, ic_hit}, 32'd0);
      else chk("instr", ic_instr, exp_q.pop_front());
    end
  end

  task automatic fill_line(input logic [31:0] pc,
                           input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input logic [31:0] w3,
                           input int flush_at, input int stall_at);
    logic [31:0] w [4];
    logic [1:0]  widx;
    w = '{w0, w1, w2, w3};
    widx = pc[3:2];
    if_req_valid = 1'b1;
    if_pc = pc;
    tick();
    chk("miss_req", {31'b0, mc_req}, 32'd1);
    chk("miss_addr", mc_addr, {pc[31:4], 4'h0});
    chk("miss_nohit", {31'b0, ic_hit}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      if (i == stall_at) begin
        rdy = 1'b0;
        mc_data_valid = 1'b1;
        mc_data = 32'hDEAD_BEEF;
        repeat (3) begin
          tick();
          chk("stall_req", {31'b0, mc_req}, 32'd1);
          chk("stall_addr", mc_addr, {pc[31:4], 4'h0});
        end
        rdy = 1'b1;
      end
      mc_data_valid = 1'b1;
      mc_data = w[i];
      flush = (i == flush_at);
      tick();
      flush = 1'b0;
    end
    mc_data_valid = 1'b0;
    if (flush_at >= 0) if_req_valid = 1'b0;
    chk("fill_done_req", {31'b0, mc_req}, 32'd0);
    chk("resp_nohit", {31'b0, ic_hit}, 32'd0);
    if (flush_at < 0) exp_q.push_back(w[widx]);
    tick();
    chk("resp_hit", {31'b0, ic_hit}, (flush_at < 0) ? 32'd1 : 32'd0);
    if_req_valid = 1'b0;
  endtask

  task automatic fetch_hit(input logic [31:0] pc, input logic [31:0] exp);
    if_req_valid = 1'b1;
    if_pc = pc;
    exp_q.push_back(exp);
    tick();
    chk("hit_lat", {31'b0, ic_hit}, 32'd1);
    chk("hit_noreq", {31'b0, mc_req}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_hit", {31'b0, ic_hit}, 32'd0);
    chk("rst_instr", ic_instr, 32'd0);
    chk("rst_req", {31'b0, mc_req}, 32'd0);
    chk("rst_addr", mc_addr, 32'd0);

    fill_line(32'h0000_0000, 32'h11, 32'h22, 32'h33, 32'h44, -1, -1);

    fetch_hit(32'h4, 32'h22);
    fetch_hit(32'h8, 32'h33);
    fetch_hit(32'hC, 32'h44);
    if_req_valid = 1'b0;
    tick();
    chk("idle_nohit", {31'b0, ic_hit}, 32'd0);

    fill_line(32'h0000_0400, 32'hAA, 32'hBB, 32'hCC, 32'hDD, -1, -1);
    fill_line(32'h0000_0000, 32'h11, 32'h22, 32'h33, 32'h44, -1, -1);
    fetch_hit(32'h8, 32'h33);
    if_req_valid = 1'b0;

    fill_line(32'h0000_0020, 32'h51, 32'h52, 32'h53, 32'h54, 1, -1);
    fetch_hit(32'h20, 32'h51);
    fetch_hit(32'h2C, 32'h54);
    if_req_valid = 1'b0;

    if_req_valid = 1'b1;
    if_pc = 32'h4;
    flush = 1'b1;
    tick();
    chk("flush_idle_hit", {31'b0, ic_hit}, 32'd0);
    chk("flush_idle_req", {31'b0, mc_req}, 32'd0);
    if_pc = 32'h200;
    tick();
    chk("flush_idle_miss_req", {31'b0, mc_req}, 32'd0);
    flush = 1'b0;
    if_req_valid = 1'b0;

    fill_line(32'h0000_0034, 32'h61, 32'h62, 32'h63, 32'h64, -1, 2);
    fetch_hit(32'h3C, 32'h64);
    if_req_valid = 1'b0;

    if_req_valid = 1'b1;
    if_pc = 32'h100;
    tick();
    chk("midfill_req", {31'b0, mc_req}, 32'd1);
    if_req_valid = 1'b0;
    mc_data_valid = 1'b1;
    mc_data = 32'h77;
    tick();
    mc_data_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midfill_rst_req", {31'b0, mc_req}, 32'd0);
    chk("midfill_rst_hit", {31'b0, ic_hit}, 32'd0);

    fill_line(32'h0000_000C, 32'h91, 32'h92, 32'h93, 32'h94, -1, -1);
    mc_data_valid = 1'b1;
    mc_data = 32'hBAD0_BAD0;
    repeat (3) begin
      tick();
      chk("idle_junk_req", {31'b0, mc_req}, 32'd0);
    end
    mc_data_valid = 1'b0;
    fetch_hit(32'h0, 32'h91);
    fetch_hit(32'h4, 32'h92);
    if_req_valid = 1'b0;
    tick();
    tick();

    chk("sb_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache at the front of the IF stage. It sits between the instruction fetcher and the memory controller. It returns one 32-bit instruction per fetch request; that word feeds both the instruction queue and the branch predictor's opcode/immediate decode. On a miss it fetches a full line from the memory controller one word at a time, installs it, then answers the stalled request.

## Interface
Parameters:
- INDEX_BITS, 6, line-index width; 2^INDEX_BITS lines.
- OFFSET_BITS, 2, word-offset width; 2^OFFSET_BITS 32-bit words per line.
- Derived TAG_BITS = 32 − INDEX_BITS − OFFSET_BITS − 2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- rdy  in  1  global ready; when low, all state and outputs hold.
- if_req_valid  in  1  fetch request valid.
- if_pc  in  32  fetch address; bits [1:0] are ignored.
- flush  in  1  ROB misprediction clear; drops any pending response.
- ic_hit  out  1  one-cycle pulse: ic_instr is valid.
- ic_instr  out  32  instruction word.
- mc_req  out  1  line-fill request to the memory controller.
- mc_addr  out  32  line-aligned fill address: low OFFSET_BITS+2 bits are 0.
- mc_data_valid  in  1  one fill word is present on mc_data.
- mc_data  in  32  fill word; words arrive in ascending address order.

## Operation
- Storage:
  - valid[2^INDEX_BITS], tag[2^INDEX_BITS][TAG_BITS], data[2^INDEX_BITS][2^OFFSET_BITS][32].
  - Reset clears all valid bits. Tag and data are not reset.
- Address split:
  - tag = if_pc[31 : INDEX_BITS+OFFSET_BITS+2]
  - index = if_pc[INDEX_BITS+OFFSET_BITS+1 : OFFSET_BITS+2]
  - word = if_pc[OFFSET_BITS+1 : 2]
- FSM states: IDLE, FILL, RESP.
  - IDLE, if_req_valid & ~flush:
    - Hit (valid & tag match): ic_hit<=1, ic_instr<=data[index][word]; stay in IDLE.
    - Miss: latch pc; mc_addr<=line-aligned pc; mc_req<=1; word counter<=0; go to FILL.
  - FILL, on each mc_data_valid: write mc_data into the line buffer at the counter position; counter++.
    - On the last word (counter == 2^OFFSET_BITS−1): mc_req<=0; write tag, valid and the full line into the latched index; go to RESP.
  - RESP: ic_hit<=~killed; ic_instr<=requested word from the line buffer; go to IDLE.
- Request rules:
  - Requests in FILL or RESP are ignored. The fetcher holds if_pc and if_req_valid until it sees ic_hit or raises flush.
  - mc_data_valid outside FILL is ignored.
- flush:
  - A flush in any state forces ic_hit=0 on the next cycle.
  - In IDLE, a request in the same cycle as flush is dropped.
  - In FILL, flush sets a killed flag. The fill still completes and installs the line, because the memory controller transaction cannot be aborted. RESP then emits no ic_hit.
  - killed clears on return to IDLE.
- Outputs:
  - ic_hit defaults to 0 every cycle unless set as above.
  - ic_instr holds its last value.
- rst has priority over rdy. rdy low freezes FSM state, counter, outputs, and the array; inputs are ignored that cycle.

## Timing
- Reset values: ic_hit=0, ic_instr=0, mc_req=0, mc_addr=0, state=IDLE, counter=0, killed=0, all valid=0.
- Hit latency: request in cycle t, ic_hit=1 in cycle t+1. One hit per cycle is sustained in IDLE.
- Miss latency:
  - Request in cycle t; mc_req=1 and mc_addr valid from t+1.
  - Last fill word accepted in cycle k; mc_req=0 from k+1, FSM in RESP at k+1.
  - ic_hit=1 at k+2. The next request is accepted at k+2.
- mc_addr is stable while mc_req=1.
- Reset mid-fill: state returns to IDLE and mc_req drops next cycle. The memory controller is reset by the same rst.

## Test plan
- Reset, then request pc=0x0000_0000 → miss; mc_req=1 with mc_addr=0x0. Supply words 0x11,0x22,0x33,0x44 → ic_hit=1 with ic_instr=0x11 two cycles after the last word.
- After that fill, requests for 0x4, 0x8, 0xC in consecutive cycles → three consecutive ic_hit pulses with 0x22, 0x33, 0x44, one cycle after each request; mc_req stays 0.
- Conflict: fill 0x000, then request 0x400 (same index, different tag) → miss, fill with 0xAA..0xDD. Re-request 0x000 → miss again.
- flush asserted during the second word of a fill → fill completes, mc_req drops, no ic_hit. A following request for the same pc hits in 1 cycle.
- rdy held low for 3 cycles mid-fill, with mc_data_valid pulsed during the stall → counter and mc_req frozen, those words ignored; fill resumes when rdy returns.
- Request for pc=0x0000_000C on a cold cache → ic_instr equals the fourth fill word. mc_data_valid pulses while in IDLE do not change the array.
